ex_issue_stage: RTL and testbench

- ID/EX boundary register that feeds the 32-bit execute ALU: op[4:0], A, B.
- Captures decoded instructions over a valid/ready handshake and holds them in a 2-entry skid buffer, so ALU-side backpressure never causes a combinational ready path to decode.
- Resolves operand forwarding from EX/MEM and MEM/WB at capture time.
- Selects immediate vs register for B, masks shift amounts, and flags op codes the ALU does not implement.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/ex_issue_stage_if.sv | 57 +++++
 rtl/operand_fwd_mux.sv | 39 +++
 rtl/ex_issue_stage.sv | 123 ++++++++++++
 tb/tb_ex_issue_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute ALU and the ID/EX issue stage:
//   - DW / RW / OPW : data, register-address and op-code widths
//   - 5-bit ALU op-code constants (NOP = 11111 is the ALU default)
//   - entry_t       : one held issue entry {op, a, b, rd, illegal}
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 5;

  localparam logic [OPW-1:0] ADD_SM = 5'b00000;
  localparam logic [OPW-1:0] ADD    = 5'b00001;
  localparam logic [OPW-1:0] SUB_SM = 5'b00010;
  localparam logic [OPW-1:0] SUB    = 5'b00011;
  localparam logic [OPW-1:0] AND    = 5'b00100;
  localparam logic [OPW-1:0] OR     = 5'b00101;
  localparam logic [OPW-1:0] XOR    = 5'b00110;
  localparam logic [OPW-1:0] XNOR   = 5'b00111;
  localparam logic [OPW-1:0] SLT    = 5'b01000;
  localparam logic [OPW-1:0] SLTU   = 5'b01001;
  localparam logic [OPW-1:0] SLL    = 5'b01010;
  localparam logic [OPW-1:0] SRL    = 5'b01011;
  localparam logic [OPW-1:0] SRA    = 5'b01100;
  localparam logic [OPW-1:0] BEQ    = 5'b01101;
  localparam logic [OPW-1:0] BNE    = 5'b01110;
  localparam logic [OPW-1:0] NOP    = 5'b11111;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RW-1:0]  rd;
    logic           illegal;
  } entry_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// -----------------------------------------------------------------------------
// ex_issue_stage_if
// Bundles the decode-side handshake, the two result bypasses and the
// ALU-side handshake of the ID/EX issue stage.
//   master : upstream/downstream environment (drives in_*, fwd_*, out_ready)
//   slave  : the issue stage (drives in_ready, out_valid, alu_*, out_rd,
//            out_illegal)
// -----------------------------------------------------------------------------
interface ex_issue_stage_if;
  import alu_pkg::*;

  // decode side
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [RW-1:0]  in_rs1_addr;
  logic [RW-1:0]  in_rs2_addr;
  logic [DW-1:0]  in_rs1_data;
  logic [DW-1:0]  in_rs2_data;
  logic [DW-1:0]  in_imm;
  logic           in_use_imm;
  logic [RW-1:0]  in_rd;

  // result bypasses
  logic           fwd_exm_we;
  logic [RW-1:0]  fwd_exm_rd;
  logic [DW-1:0]  fwd_exm_data;
  logic           fwd_mwb_we;
  logic [RW-1:0]  fwd_mwb_rd;
  logic [DW-1:0]  fwd_mwb_data;

  // ALU side
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [RW-1:0]  out_rd;
  logic           out_illegal;

  modport master (
    output in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd,
           fwd_exm_we, fwd_exm_rd, fwd_exm_data, fwd_mwb_we, fwd_mwb_rd, fwd_mwb_data,
           out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd,
           fwd_exm_we, fwd_exm_rd, fwd_exm_data, fwd_mwb_we, fwd_mwb_rd, fwd_mwb_data,
           out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, out_rd, out_illegal
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// -----------------------------------------------------------------------------
// operand_fwd_mux
// Resolves one source operand at capture time.
//   addr / rf_data            : source register number and regfile read data
//   exm_we / exm_rd / exm_data: EX/MEM bypass (highest priority)
//   mwb_we / mwb_rd / mwb_data: MEM/WB bypass
//   operand                   : resolved value; register 0 always reads 0
// Build option: EX_ISSUE_FWD_EN enables the bypasses; without it the bypass
// inputs are ignored and the operand is the regfile data.
// -----------------------------------------------------------------------------
module operand_fwd_mux
  import alu_pkg::*;
(
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_we,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_we,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] operand
);

`ifdef EX_ISSUE_FWD_EN
  always_comb begin
    if (addr == '0)                        operand = '0;
    else if (exm_we && (exm_rd == addr))   operand = exm_data;
    else if (mwb_we && (mwb_rd == addr))   operand = mwb_data;
    else                                   operand = rf_data;
  end
`else
  assign operand = (addr == '0) ? '0 : rf_data;

  logic unused_fwd;
  assign unused_fwd = ^{exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data};
`endif

endmodule

// File: rtl/ex_issue_stage.sv
// -----------------------------------------------------------------------------
// ex_issue_stage
// ID/EX boundary register in front of the 32-bit execute ALU. Decoded
// instructions are captured over valid/ready into a main register (which
// drives the ALU) backed by one skid register, so in_ready is a flop and
// never depends combinationally on out_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of every held entry
//   bus        : ex_issue_stage_if.slave (decode handshake, bypasses, ALU side)
// Capture-time processing: operand bypass, immediate select for B, shift
// amount masking, branch ops lose their destination, unimplemented ops are
// flagged illegal and turned into NOP.
// Build option: EX_ISSUE_FWD_EN (see operand_fwd_mux).
// -----------------------------------------------------------------------------
module ex_issue_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ex_issue_stage_if.slave  bus
);

  // state = {main_valid, skid_valid}; 01 cannot occur
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_FULL1 = 2'b10;
  localparam logic [1:0] S_FULL2 = 2'b11;

  logic [1:0]    state_q, state_d;
  logic          in_ready_q;
  entry_t        main_q, skid_q, new_entry;
  logic [DW-1:0] rs1_val, rs2_val, b_raw;
  logic          accept, consume;

  operand_fwd_mux u_rs1 (
    .addr     (bus.in_rs1_addr),
    .rf_data  (bus.in_rs1_data),
    .exm_we   (bus.fwd_exm_we),
    .exm_rd   (bus.fwd_exm_rd),
    .exm_data (bus.fwd_exm_data),
    .mwb_we   (bus.fwd_mwb_we),
    .mwb_rd   (bus.fwd_mwb_rd),
    .mwb_data (bus.fwd_mwb_data),
    .operand  (rs1_val)
  );

  operand_fwd_mux u_rs2 (
    .addr     (bus.in_rs2_addr),
    .rf_data  (bus.in_rs2_data),
    .exm_we   (bus.fwd_exm_we),
    .exm_rd   (bus.fwd_exm_rd),
    .exm_data (bus.fwd_exm_data),
    .mwb_we   (bus.fwd_mwb_we),
    .mwb_rd   (bus.fwd_mwb_rd),
    .mwb_data (bus.fwd_mwb_data),
    .operand  (rs2_val)
  );

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = state_q[1] && bus.out_ready;

  // Entry as it will be stored; bypass values are frozen here and never
  // refreshed while the entry waits in main or skid.
  always_comb begin : build_entry
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    new_entry         = '0;
    b_raw             = bus.in_use_imm ? bus.in_imm : rs2_val;
    new_entry.illegal = (bus.in_op > BNE);
    new_entry.op      = new_entry.illegal ? NOP : bus.in_op;
    new_entry.a       = rs1_val;
    new_entry.b       = (bus.in_op inside {SLL, SRL, SRA}) ? {{(DW-5){1'b0}}, b_raw[4:0]} : b_raw;
    new_entry.rd      = (bus.in_op inside {BEQ, BNE}) ? '0 : bus.in_rd;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL1;
      S_FULL1: begin
        if (accept && !consume)      state_d = S_FULL2;
        else if (!accept && consume) state_d = S_EMPTY;
      end
      S_FULL2: if (consume) state_d = S_FULL1;
      default: state_d = S_EMPTY;
    endcase
    // A consume in the flush cycle needs no action: the entry is gone either way.
    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      // NOTE: the entry registers are reset too, because they drive the ALU outputs and those must read zero in reset.
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      in_ready_q <= !state_d[0];
      if (!flush) begin
        case (state_q)
          S_EMPTY: if (accept) main_q <= new_entry;
          S_FULL1: begin
            if (accept && consume) main_q <= new_entry;
            else if (accept)       skid_q <= new_entry;
          end
          S_FULL2: if (consume) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = state_q[1];
  assign bus.alu_op      = main_q.op;
  assign bus.alu_a       = main_q.a;
  assign bus.alu_b       = main_q.b;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_issue_stage
// Self-checking bench for ex_issue_stage. A queue of expected entries (at
// most two) models the stage; each entry is computed from the operand and
// op-code rules. Directed cases are followed by randomized traffic.
// Honours EX_ISSUE_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ex_issue_stage;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  ex_issue_stage_if bus ();

  ex_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  entry_t model_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 5'd0) return 32'd0;
`ifdef EX_ISSUE_FWD_EN
    if (bus.fwd_exm_we && bus.fwd_exm_rd == addr) return bus.fwd_exm_data;
    if (bus.fwd_mwb_we && bus.fwd_mwb_rd == addr) return bus.fwd_mwb_data;
`endif
    return rf;
  endfunction

  function automatic entry_t ref_entry();
    entry_t      e;
    int          op;
    logic [31:0] b;
    op = int'(bus.in_op);
    b  = bus.in_use_imm ? bus.in_imm : ref_operand(bus.in_rs2_addr, bus.in_rs2_data);
    if (op >= 10 && op <= 12) b = b % 32;
    e.op      = (op > 14) ? 5'd31 : bus.in_op;
    e.a       = ref_operand(bus.in_rs1_addr, bus.in_rs1_data);
    e.b       = b;
    e.rd      = (op == 13 || op == 14) ? 5'd0 : bus.in_rd;
    e.illegal = (op > 14);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, bus.out_valid, model_q.size() > 0);
    check({tag, ".in_ready"}, bus.in_ready, model_q.size() < 2);
    if (model_q.size() > 0) begin
      check({tag, ".alu_op"}, bus.alu_op, model_q[0].op);
      check({tag, ".alu_a"}, bus.alu_a, model_q[0].a);
      check({tag, ".alu_b"}, bus.alu_b, model_q[0].b);
      check({tag, ".out_rd"}, bus.out_rd, model_q[0].rd);
      check({tag, ".out_illegal"}, bus.out_illegal, model_q[0].illegal);
    end
  endtask

  // One clock: update the model with the values present at the edge, then
  // compare on the falling edge.
  task automatic tick(input string tag);
    bit acc, con;
    @(posedge clk);
    acc = bus.in_valid && (model_q.size() < 2);
    con = (model_q.size() > 0) && bus.out_ready;
    if (flush) model_q.delete();
    else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(ref_entry());
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_op        = '0;
    bus.in_rs1_addr  = '0;
    bus.in_rs2_addr  = '0;
    bus.in_rs1_data  = '0;
    bus.in_rs2_data  = '0;
    bus.in_imm       = '0;
    bus.in_use_imm   = 1'b0;
    bus.in_rd        = '0;
    bus.fwd_exm_we   = 1'b0;
    bus.fwd_exm_rd   = '0;
    bus.fwd_exm_data = '0;
    bus.fwd_mwb_we   = 1'b0;
    bus.fwd_mwb_rd   = '0;
    bus.fwd_mwb_data = '0;
    bus.out_ready    = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic random_inputs();
    bus.in_valid     = 1'($urandom_range(0, 1));
    bus.in_op        = 5'($urandom_range(0, 31));
    bus.in_rs1_addr  = 5'($urandom_range(0, 7));
    bus.in_rs2_addr  = 5'($urandom_range(0, 7));
    bus.in_rs1_data  = $urandom;
    bus.in_rs2_data  = $urandom;
    bus.in_imm       = $urandom;
    bus.in_use_imm   = 1'($urandom_range(0, 1));
    bus.in_rd        = 5'($urandom_range(0, 31));
    bus.fwd_exm_we   = 1'($urandom_range(0, 1));
    bus.fwd_exm_rd   = 5'($urandom_range(0, 7));
    bus.fwd_exm_data = $urandom;
    bus.fwd_mwb_we   = 1'($urandom_range(0, 1));
    bus.fwd_mwb_rd   = 5'($urandom_range(0, 7));
    bus.fwd_mwb_data = $urandom;
    bus.out_ready    = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check({tag, ".in_ready"}, bus.in_ready, 1'b1);
    check({tag, ".alu_op"}, bus.alu_op, 32'd0);
    check({tag, ".alu_a"}, bus.alu_a, 32'd0);
    check({tag, ".alu_b"}, bus.alu_b, 32'd0);
    check({tag, ".out_rd"}, bus.out_rd, 32'd0);
    check({tag, ".out_illegal"}, bus.out_illegal, 1'b0);
  endtask

  // Two accepts with the ALU stalled: leaves the stage in FULL2.
  task automatic fill_two(input string tag);
    random_inputs();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick({tag, ".fill0"});
    random_inputs();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick({tag, ".fill1"});
    check({tag, ".in_ready_low"}, bus.in_ready, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single add: 5 + 7
    bus.in_valid    = 1'b1;
    bus.in_op       = ADD;
    bus.in_rs1_addr = 5'd3;
    bus.in_rs1_data = 32'd5;
    bus.in_rs2_addr = 5'd4;
    bus.in_rs2_data = 32'd7;
    bus.in_rd       = 5'd9;
    bus.out_ready   = 1'b1;
    tick("add");
    check("add.valid", bus.out_valid, 1'b1);
    check("add.a", bus.alu_a, 32'd5);
    check("add.b", bus.alu_b, 32'd7);
    check("add.rd", bus.out_rd, 32'd9);
    bus.in_valid = 1'b0;
    tick("add.drain");

    // backpressure then release, order preserved by the model
    fill_two("bp");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick("bp.rel0");
    tick("bp.rel1");
    check("bp.empty", bus.out_valid, 1'b0);

    // forwarding priority and register 0
    idle_inputs();
    bus.in_valid     = 1'b1;
    bus.in_op        = ADD;
    bus.in_rs1_addr  = 5'd6;
    bus.in_rs1_data  = 32'h5555;
    bus.fwd_exm_we   = 1'b1;
    bus.fwd_exm_rd   = 5'd6;
    bus.fwd_exm_data = 32'hAAAA;
    bus.fwd_mwb_we   = 1'b1;
    bus.fwd_mwb_rd   = 5'd6;
    bus.fwd_mwb_data = 32'hBBBB;
    bus.out_ready    = 1'b1;
    tick("fwd.prio");
`ifdef EX_ISSUE_FWD_EN
    check("fwd.prio.a", bus.alu_a, 32'hAAAA);
`else
    check("fwd.off.a", bus.alu_a, 32'h5555);
`endif
    bus.in_rs1_addr  = 5'd0;
    bus.in_rs1_data  = 32'h7777;
    bus.fwd_exm_rd   = 5'd0;
    bus.fwd_exm_data = 32'h1234;
    bus.fwd_mwb_we   = 1'b0;
    tick("fwd.r0");
    check("fwd.r0.a", bus.alu_a, 32'd0);

    // shift mask and illegal op
    idle_inputs();
    bus.in_valid   = 1'b1;
    bus.in_op      = SLL;
    bus.in_use_imm = 1'b1;
    bus.in_imm     = 32'h0000_0123;
    bus.in_rd      = 5'd2;
    bus.out_ready  = 1'b1;
    tick("shift");
    check("shift.b", bus.alu_b, 32'h3);
    bus.in_op = 5'b10101;
    tick("illegal");
    check("illegal.flag", bus.out_illegal, 1'b1);
    check("illegal.op", bus.alu_op, 32'h1F);
    bus.in_op = BEQ;
    bus.in_rd = 5'd17;
    tick("branch");
    check("branch.rd", bus.out_rd, 32'd0);
    bus.in_valid = 1'b0;
    tick("misc.drain");

    // flush in FULL2 with a concurrent in_valid
    fill_two("fl2");
    random_inputs();
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    tick("fl2.flush");
    check("fl2.valid", bus.out_valid, 1'b0);
    check("fl2.ready", bus.in_ready, 1'b1);
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick("fl2.after");

    // flush in FULL1 while an accept and a consume happen
    random_inputs();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick("fl1.fill");
    random_inputs();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    tick("fl1.flush");
    check("fl1.valid", bus.out_valid, 1'b0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick("fl1.after");

    // asynchronous reset in the middle of a cycle while FULL2
    fill_two("ar");
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("ar.async");
    model_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("ar.release");
    check("ar.ready", bus.in_ready, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      flush = ($urandom_range(0, 19) == 0);
      tick("rand");
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    tick("final.drain0");
    tick("final.drain1");
    check("final.empty", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
